mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle RV32I core's single-port memory interface.
- Accepts word-aligned read and write requests with byte enables, backed by an internal synchronous RAM.
- Returns a single-cycle mem_resp after a fixed, parameterised latency.
- Used as the synthesizable memory behind the datapath/control pair, for both instruction fetch and data access.

Parameters:
- ADDR_WIDTH, 10: word-index bits; capacity is 2^ADDR_WIDTH words (default 4 KiB).
- BASE_ADDR, 32'h0000_0000: byte address mapped to word 0; must be 4-byte aligned.
- LATENCY, 3: cycles from request acceptance to mem_resp; legal range is 1 or greater.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising clk edge).
- mem_read  in  1  read request; held by the initiator until mem_resp.
- mem_write  in  1  write request; held by the initiator until mem_resp.
- mem_byte_enable  in  4  per-byte write strobes; bit i selects wdata[8i+7:8i].
- mem_address  in  32  byte address; bits [1:0] are ignored.
- mem_wdata  in  32  write data, pre-shifted to byte lanes by the initiator.
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid in the mem_resp cycle.
- mem_err  out  1  qualifies mem_resp: out-of-range address or protocol violation.

Behaviour:
- Reset values:
  - State IDLE.
  - mem_resp=0, mem_err=0, mem_rdata=32'h0, latency counter=0.
  - RAM contents are not cleared.
- State IDLE:
  - If mem_read|mem_write is high, accept the request at the clock edge and go to BUSY.
  - At acceptance, capture the address, wdata, byte enables, op and the error flag.
  - Counter is loaded with LATENCY-1.
- State BUSY:
  - Counter decrements each cycle.
  - When the counter is 0, go to RESP.
  - With LATENCY=1, BUSY lasts zero cycles: IDLE goes directly to RESP.
- State RESP:
  - mem_resp=1 for exactly this cycle; next state is IDLE.
  - In IDLE, a still-asserted request is accepted as a new transaction (initiator must drop it after resp).
- Latency: a request first seen high in cycle N produces mem_resp in cycle N+LATENCY.
- Index and range:
  - Word index = (mem_address - BASE_ADDR) >> 2, 32-bit unsigned subtraction.
  - Out of range if the index is 2^ADDR_WIDTH or greater (this includes addresses below BASE_ADDR, which wrap to a large index).
- Write:
  - Committed to the RAM on the acceptance edge.
  - Only lanes with the byte enable set are updated.
  - mem_byte_enable=4'b0000 is legal: no change, normal resp.
- Read:
  - RAM read at acceptance; result registered into mem_rdata, shown in RESP.
  - mem_rdata holds its value after RESP until the next read resp.
- Errors:
  - Out of range: no RAM write, mem_rdata=32'h0, mem_err=1 in RESP.
  - mem_read and mem_write both high at acceptance: treated as an error, no write, mem_rdata=0, mem_err=1.
  - mem_err is 0 whenever mem_resp=0.
- Input changes while in BUSY/RESP are ignored; the captured request is authoritative.
- Reset mid-transaction: return to IDLE, drop the pending resp, no mem_resp emitted. A write already committed remains.
- Read-after-write to the same word in consecutive transactions returns the new data.

Optional Feature:
- Macro: MEM_RESPONDER_RANDOM_LAT_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and steps every cycle.
  - At acceptance, extra = lfsr[1:0] is sampled and the counter is loaded with LATENCY-1+extra.
  - Latency is therefore LATENCY to LATENCY+3; the latency is never shorter than LATENCY.
- Undefined: no LFSR; latency is exactly LATENCY.

Decomposition:
- Package mem_responder_types:
  - State enum {IDLE, BUSY, RESP}.
  - LFSR_SEED=8'hA5 and the LFSR tap mask.
  - mem_req_t struct {addr, wdata, mbe, read, write, err} for the captured request.
- Sub-module mem_array:
  - Byte-enabled single-port synchronous RAM, parameter ADDR_WIDTH.
  - Ports: clk, we, be[3:0], idx, wdata, rdata (registered).
  - No reset.

Test Plan:
- Write/read, LATENCY=3: write addr 32'h10, data 32'hDEADBEEF, mbe 4'hF at cycle 5 → mem_resp=1 in cycle 8 only, mem_err=0. Read 32'h10 → mem_rdata=32'hDEADBEEF in its resp cycle.
- Byte lanes: word 32'h20 holds 32'h11223344; write mbe=4'b0100, wdata=32'h00AB0000, then read 32'h22 → 32'h11AB3344 (address low bits ignored).
- Range error: BASE_ADDR=32'h4000, read 32'h3FFC → mem_resp with mem_err=1, rdata=0. Write 32'h5000 with ADDR_WIDTH=10 → mem_err=1, and a later read of 32'h4000 is unchanged.
- Protocol violation: mem_read=mem_write=1 → mem_err=1, no RAM write. Back-to-back: the request held one cycle past resp is re-accepted and a second resp follows LATENCY cycles later.
- Reset mid-op: pull rst=0 in the cycle after acceptance → no mem_resp, all outputs 0. The next request after rst=1 completes normally with latency LATENCY.
- With MEM_RESPONDER_RANDOM_LAT_EN: 200 reads → every latency is in 3..6, all four values occur, and data is always correct.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types for mem_responder: FSM states, captured-request record and the
// latency-jitter LFSR constants.
package mem_responder_types;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 of x^8+x^6+x^5+x^4+1 map to bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    logic        read;
    logic        write;
    logic        err;
  } mem_req_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Byte-enabled single-port synchronous RAM with a registered read port.
module mem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  // NOTE: storage has no reset; clearing a RAM array would turn it into flops.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem_q[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the RV32I core's single-port bus.
// Optional macro MEM_RESPONDER_RANDOM_LAT_EN adds 0..3 cycles of LFSR jitter.
module mem_responder
  import mem_responder_types::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int CNT_W = $clog2(LATENCY + 4) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, load_val;
  mem_req_t         req_q, req_d, req_in, req_cur;
  logic [31:0]      hold_q, hold_d;
  logic [31:0]      ram_rdata, resp_rdata;
  logic [31:0]      offset_in, offset_cur;
  logic             range_err, accept, ram_we;
  logic             unused_bits;

  assign offset_in = mem_address - BASE_ADDR;
  // Addresses below BASE_ADDR wrap to a huge index and land here as well.
  assign range_err = |offset_in[31:ADDR_WIDTH+2];

  always_comb begin
    req_in       = '0;
    req_in.addr  = mem_address;
    req_in.wdata = mem_wdata;
    req_in.mbe   = mem_byte_enable;
    req_in.read  = mem_read;
    req_in.write = mem_write;
    req_in.err   = range_err | (mem_read & mem_write);
  end

  // Outside IDLE the RAM port is held on the captured request, so the read
  // data stays stable while the transaction waits out its latency.
  assign req_cur    = (state_q == IDLE) ? req_in : req_q;
  assign offset_cur = req_cur.addr - BASE_ADDR;

  assign accept = rst && (state_q == IDLE) && (mem_read || mem_write);
  assign ram_we = accept && req_cur.write && !req_cur.err;

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem_array (
    .clk  (clk),
    .we   (ram_we),
    .be   (req_cur.mbe),
    .idx  (offset_cur[ADDR_WIDTH+1:2]),
    .wdata(req_cur.wdata),
    .rdata(ram_rdata)
  );

  assign unused_bits = ^{offset_cur[31:ADDR_WIDTH+2], offset_cur[1:0], offset_in[1:0]};

`ifdef MEM_RESPONDER_RANDOM_LAT_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_step(lfsr_q);
  end

  assign load_val = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[1:0]);
`else
  assign load_val = CNT_W'(LATENCY - 1);
`endif

  // Errors read as zero; a clean write leaves the last read data on the bus.
  assign resp_rdata = req_cur.err  ? 32'h0 :
                      req_cur.read ? ram_rdata : hold_q;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d   = req_in;
          cnt_d   = load_val;
          state_d = (load_val == '0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        hold_d  = resp_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      hold_q  <= hold_d;
    end
  end

  assign mem_resp  = (state_q == RESP);
  assign mem_err   = mem_resp && req_cur.err;
  assign mem_rdata = mem_resp ? resp_rdata : hold_q;

endmodule
